// File: rtl/light_uart_pkg.sv
// Shared types and helpers for the light UART receive path.
package light_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int DATA_W_DEF  = 8;
    localparam int SYNC_STAGES = 2;
    localparam int BCLK_W      = 20;

    function automatic logic [BCLK_W-1:0] bit_clks_f(input logic [15:0] dbr);
        return {dbr, 4'b0000};
    endfunction

endpackage

// File: rtl/light_uart_rx_fifo_if.sv
// Show-ahead byte stream from the receiver to its consumer.
interface light_uart_rx_fifo_if #(
    parameter int DATA_W = light_uart_pkg::DATA_W_DEF
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/light_uart_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry a wrap bit for full/empty.
module light_uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [CW-1:0]    count_next_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign count_o = wptr_q - rptr_q;

    // A pop frees the head slot, so a full FIFO can still take a push.
    always_comb begin
        do_pop       = pop_i & ~empty_o;
        do_push      = push_i & (~full_o | do_pop);
        wptr_d       = wptr_q + CW'(do_push);
        rptr_d       = rptr_q + CW'(do_pop);
        count_next_o = count_o + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/light_uart_rx_fifo.sv
// UART receiver (8N1+, bit = dbr<<4 clocks) feeding a show-ahead FIFO.
// Optional even parity bit when LIGHT_UART_RX_PARITY_EN is defined.
module light_uart_rx_fifo
    import light_uart_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int RTS_THRESH = 12,
    localparam int CW    = $clog2(FIFO_DEPTH) + 1,
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           dbr,
    input  logic                  rxd,
    light_uart_rx_fifo_if.master  rx,
    output logic [CW-1:0]         fifo_count,
    output logic                  rts_n,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  parity_err,
    input  logic                  err_clr
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e          state_q, state_d;
    logic [BCLK_W-1:0]  cnt_q, cnt_d;
    logic [BCLK_W-1:0]  bc_q, bc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic               brk_q, brk_d;
    logic               push;
    logic               fe_set;
    logic               fe_q, fe_d;
    logic               ovr_q, ovr_d;
    logic               rts_q, rts_d;

    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_cnt_next;
    logic [DATA_W-1:0]  fifo_rdata;

`ifdef LIGHT_UART_RX_PARITY_EN
    logic               parbad_q, parbad_d;
    logic               pe_set;
    logic               pe_q, pe_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bc_d    = bc_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        brk_d   = brk_q;
        push    = 1'b0;
        fe_set  = 1'b0;
`ifdef LIGHT_UART_RX_PARITY_EN
        parbad_d = parbad_q;
        pe_set   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                brk_d = 1'b0;
                if (!rxs && dbr != 16'd0) begin
                    bc_d    = bit_clks_f(dbr);
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == (bc_q >> 1) - 1'b1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == bc_q - 1'b1) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rxs;
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef LIGHT_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef LIGHT_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == bc_q - 1'b1) begin
                    cnt_d    = '0;
                    parbad_d = (^sh_q) ^ rxs;
                    pe_set   = (^sh_q) ^ rxs;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                // After a 0 stop bit, hold here until the line idles again.
                if (brk_q) begin
                    cnt_d = cnt_q;
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == bc_q - 1'b1) begin
                    if (rxs) begin
`ifdef LIGHT_UART_RX_PARITY_EN
                        push = ~parbad_q;
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        fe_set = 1'b1;
                        brk_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bc_q    <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            brk_q   <= brk_d;
        end
    end

    assign pop = rx.rx_valid & rx.rx_ready;

    light_uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .wdata_i      (sh_q),
        .pop_i        (pop),
        .rdata_o      (fifo_rdata),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .count_next_o (fifo_cnt_next)
    );

    assign rx.rx_data  = fifo_rdata;
    assign rx.rx_valid = ~fifo_empty;

    // A coincident set beats err_clr so no event is lost.
    always_comb begin
        fe_d  = fe_set | (fe_q & ~err_clr);
        ovr_d = (push & fifo_full & ~pop) | (ovr_q & ~err_clr);
        rts_d = (fifo_cnt_next >= CW'(RTS_THRESH));
`ifdef LIGHT_UART_RX_PARITY_EN
        pe_d  = pe_set | (pe_q & ~err_clr);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fe_q  <= 1'b0;
            ovr_q <= 1'b0;
            rts_q <= 1'b0;
        end else begin
            fe_q  <= fe_d;
            ovr_q <= ovr_d;
            rts_q <= rts_d;
        end
    end

`ifdef LIGHT_UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parbad_q <= 1'b0;
            pe_q     <= 1'b0;
        end else begin
            parbad_q <= parbad_d;
            pe_q     <= pe_d;
        end
    end

    assign parity_err = pe_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = fe_q;
    assign overrun   = ovr_q;
    assign rts_n     = rts_q;

endmodule

// File: tb/tb_light_uart_rx_fifo.sv
// Directed bench for light_uart_rx_fifo: latency, framing, FIFO, flow control.
module tb_light_uart_rx_fifo;
    import light_uart_pkg::*;

    localparam int BC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dbr;
    logic        rxd;
    logic [4:0]  fifo_count;
    logic        rts_n;
    logic        frame_err;
    logic        overrun;
    logic        parity_err;
    logic        err_clr;

    int n_checks = 0;
    int n_errors = 0;

    light_uart_rx_fifo_if #(.DATA_W(8)) rif ();

    light_uart_rx_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .dbr        (dbr),
        .rxd        (rxd),
        .rx         (rif),
        .fifo_count (fifo_count),
        .rts_n      (rts_n),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        stopb;
        logic [15:0] dbr;
        logic        exp_push;
        logic        exp_fe;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold_bit(input logic v);
        rxd = v;
        repeat (BC) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input int nstop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(stopb);
        for (int i = 1; i < nstop; i++) hold_bit(1'b1);
        rxd = 1'b1;
        repeat (2) tick();
    endtask

    task automatic pop_one();
        rif.rx_ready = 1'b1;
        tick();
        rif.rx_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rx_valid"}, 32'(rif.rx_valid), 32'd0);
        check({tag, " fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, " rts_n"}, 32'(rts_n), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
        check({tag, " parity_err"}, 32'(parity_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h00, 1'b1, 16'd1, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 16'd1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 16'd1, 1'b0, 1'b1};
        vecs[3] = '{8'h81, 1'b1, 16'd1, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 16'd1, 1'b1, 1'b0};

        reset        = 1'b1;
        dbr          = 16'd1;
        rxd          = 1'b1;
        err_clr      = 1'b0;
        rif.rx_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_state("reset");

        // First-byte latency: valid appears on the 155th edge after the fall.
        fork
            send_frame(8'hA5, 1'b1, 3);
            begin
                repeat (154) tick();
                check("lat_before", 32'(rif.rx_valid), 32'd0);
                tick();
                check("lat_valid", 32'(rif.rx_valid), 32'd1);
                check("lat_data", 32'(rif.rx_data), 32'hA5);
            end
        join
        check("a5_frame_err", 32'(frame_err), 32'd0);
        pop_one();
        check("a5_popped", 32'(fifo_count), 32'd0);

        // Short low glitch is a false start.
        rxd = 1'b0;
        repeat (5) tick();
        rxd = 1'b1;
        repeat (40) tick();
        check("false_start_cnt", 32'(fifo_count), 32'd0);
        check("false_start_valid", 32'(rif.rx_valid), 32'd0);
        check("false_start_state", 32'(dut.state_q), 32'(IDLE));

        for (int v = 0; v < 6; v++) begin
            dbr = vecs[v].dbr;
            send_frame(vecs[v].data, vecs[v].stopb, 3);
            check($sformatf("vec%0d valid", v), 32'(rif.rx_valid),
                  32'(vecs[v].exp_push));
            check($sformatf("vec%0d count", v), 32'(fifo_count),
                  32'(vecs[v].exp_push));
            check($sformatf("vec%0d frame_err", v), 32'(frame_err),
                  32'(vecs[v].exp_fe));
            if (vecs[v].exp_push) begin
                check($sformatf("vec%0d data", v), 32'(rif.rx_data),
                      32'(vecs[v].data));
                pop_one();
            end
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check($sformatf("vec%0d fe_clr", v), 32'(frame_err), 32'd0);
            check($sformatf("vec%0d empty", v), 32'(fifo_count), 32'd0);
        end
        dbr = 16'd1;

        // Flow control: rts_n rises with the 12th byte, falls after a pop.
        for (int i = 0; i < 12; i++) begin
            send_frame(8'(8'h20 + i), 1'b1, 1);
            check($sformatf("rts fill%0d", i), 32'(rts_n),
                  32'((i + 1) >= 12));
        end
        check("rts_cnt12", 32'(fifo_count), 32'd12);
        pop_one();
        check("rts_cnt11", 32'(fifo_count), 32'd11);
        check("rts_drop", 32'(rts_n), 32'd0);
        for (int i = 1; i < 12; i++) begin
            check($sformatf("rts drain%0d", i), 32'(rif.rx_data),
                  32'(8'h20 + i));
            pop_one();
        end
        check("rts_drained", 32'(fifo_count), 32'd0);

        // Overrun: 17th byte is dropped, first 16 drain in order.
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 1);
            check($sformatf("ovr cnt%0d", i), 32'(fifo_count),
                  32'((i + 1) > 16 ? 16 : (i + 1)));
            check($sformatf("ovr flag%0d", i), 32'(overrun),
                  32'(i == 16));
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovr drain%0d", i), 32'(rif.rx_data), 32'(i));
            pop_one();
        end
        check("ovr_empty", 32'(rif.rx_valid), 32'd0);

        // Frame error set while err_clr is held: set wins, then clears.
        err_clr = 1'b1;
        fork
            send_frame(8'h3C, 1'b0, 2);
            begin
                repeat (155) tick();
                check("setwins_fe", 32'(frame_err), 32'd1);
                tick();
                check("setwins_clr", 32'(frame_err), 32'd0);
            end
        join
        err_clr = 1'b0;
        check("setwins_cnt", 32'(fifo_count), 32'd0);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Reset during data bit 4 of 0x81 with a byte already queued.
        send_frame(8'h77, 1'b1, 1);
        check("pre_reset_cnt", 32'(fifo_count), 32'd1);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(i == 0);
        rxd = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rxd   = 1'b1;
        check_reset_state("midreset");
        repeat (4 * BC) tick();
        check("post_reset_idle", 32'(fifo_count), 32'd0);
        send_frame(8'h42, 1'b1, 3);
        check("post_reset_valid", 32'(rif.rx_valid), 32'd1);
        check("post_reset_data", 32'(rif.rx_data), 32'h42);
        check("post_reset_fe", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/light_uart_rx_fifo.md
Name: light_uart_rx_fifo

Overview:
- Synthesizable UART receive stage, directly downstream of the light UART transactor's txd line.
- Deserializes 8N1+ frames using the same divisor convention as the transactor: bit period = DBR<<4 clocks.
- Buffers bytes in a show-ahead FIFO with a valid/ready consumer interface.
- Drives rts_n back to the transactor's cts for flow control.

Parameters:
- DATA_W, 8: character width in bits, LSB first on the line.
- FIFO_DEPTH, 16: FIFO entries; must be a power of 2 and at least 4.
- RTS_THRESH, 12: fill level at or above which rts_n deasserts (goes high); must be less than or equal to FIFO_DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dbr  in  16  divisor; bit period = dbr<<4 clocks; 0 = receiver disabled.
- rxd  in  1  serial line, idle high, asynchronous.
- rx_data  out  DATA_W  FIFO head byte (show-ahead).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer pops on rx_valid && rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current fill level.
- rts_n  out  1  0 = send allowed; 1 = stop.
- frame_err  out  1  sticky: a stop bit was sampled 0.
- overrun  out  1  sticky: a byte was received while the FIFO was full.
- parity_err  out  1  sticky: parity mismatch; tied 0 without the optional feature.
- err_clr  in  1  clears all sticky flags.

Behaviour:
- Reset values: rx_valid=0, fifo_count=0, rts_n=0, frame_err=0, overrun=0, parity_err=0, FSM=IDLE, FIFO pointers=0. rx_data is don't-care while rx_valid=0.
- Input synchronization: rxd passes through a 2-flop synchronizer (sync flops reset to 1). All decisions use the synchronized value rxs.
- Divisor latching: bit_clks = {dbr,4'b0} is latched at start-bit detection. A dbr change mid-frame takes effect on the next frame.
- IDLE: if rxs==0 and dbr!=0, latch bit_clks, clear the counter, go to START.
- START: count to bit_clks>>1 (mid start bit).
  - rxs==0 → DATA, bit index 0.
  - rxs==1 → false start: discard, go to IDLE.
- DATA: at each bit_clks boundary, shift rxs into bit[idx]. After DATA_W samples → STOP (or PARITY when the feature is enabled).
- STOP: after bit_clks, sample rxs.
  - rxs==1 → push the byte.
  - rxs==0 → set frame_err, discard the byte, then wait for rxs==1 before returning to IDLE (break tolerance).
  - Extra stop bits (the transactor sends 3) are absorbed in IDLE.
- Push latency: a push is registered in the stop-sample cycle; rx_valid is visible the following cycle. Total rxd-fall-to-rx_valid = 2 (sync) + bit_clks/2 + (DATA_W+1)*bit_clks + 1 cycles.
- FIFO: pointers are $clog2(FIFO_DEPTH)+1 bits wide, with the wrap bit used for full/empty. Cases:
  - Push when full and no pop: byte dropped, overrun set.
  - Push and pop in the same cycle: both succeed, count unchanged, including when full.
  - Pop when empty: ignored.
- rts_n: registered; equals (next fifo_count >= RTS_THRESH).
- Sticky flags: err_clr clears them. If a set event and err_clr coincide, set wins.
- Reset mid-frame: FSM returns to IDLE; the partial byte is discarded and the FIFO is emptied.

Optional Feature:
- Macro: LIGHT_UART_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and samples one even-parity bit at the bit_clks boundary. On mismatch, parity_err is set and the byte is discarded after the stop bit is checked (frame_err still evaluated).
- Undefined: no PARITY state; parity_err is tied 0; the frame is start + DATA_W + stop.

Decomposition:
- Package light_uart_pkg:
  - rx FSM enum {IDLE, START, DATA, PARITY, STOP}.
  - Default DATA_W.
  - SYNC_STAGES=2.
  - Function for the bit_clks computation.
- Sub-module light_uart_sync_fifo: parameterized width/depth, show-ahead, push/pop/full/empty/count.
- The top-level holds the synchronizer, baud counter, FSM, and flags.

Test Plan:
- dbr=1 (bit_clks=16); send 0xA5 with 3 stop bits → rx_data=0xA5, rx_valid at cycle 2+8+144+1 after the rxd fall; frame_err=0.
- Hold rxd low for 5 clocks, then high (dbr=1) → no push, FSM back in IDLE, fifo_count=0.
- Send 0x3C with the stop bit forced 0 → frame_err=1, fifo_count=0; err_clr pulse → frame_err=0.
- rx_ready=0; send 17 bytes 0x00..0x10 → fifo_count=16, overrun=1; draining yields 0x00..0x0F in order.
- rx_ready=0; after the 12th byte rts_n=1; pop one byte (count 11) → rts_n=0 the next cycle.
- Assert reset at DATA bit 4 of 0x81 → all outputs at reset values; a subsequent 0x42 frame is received correctly.
